apb_master_bridge: RTL

- APB initiator that turns a simple valid/ready command stream into APB3 transfers: IDLE, then SETUP, then ACCESS, with wait states.
- Returns one response per command on a valid/ready response channel.
- Drives the master side of apb_interface; used by the host/DMA path and the testbench to program the matrix-multiplier register slave.
- Commands are buffered in a small FIFO so the issuer is not stalled by slave wait states.

---
 rtl/apb_master_bridge_pkg.sv | 13 +
 rtl/apb_master_bridge_cmd_fifo.sv | 74 +++++++
 rtl/apb_master_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

    localparam int APB_ADDR_WIDTH_DEF = 32;
    localparam int APB_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_cmd_fifo.sv
// Command FIFO for the APB master bridge: registered not_full/empty flags,
// no fall-through (an entry pushed at one edge is poppable at the next).
module apb_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_full,
    output logic             empty
);
    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_s;
    logic             not_full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // Qualified push/pop and next occupancy.
    always_comb begin
        push_s = push && not_full_r;
        pop_s  = pop && !empty_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W + 1){1'b0}};
            not_full_r <= 1'b1;
            empty_r    <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_s;
            not_full_r <= (count_s != DEPTH_C);
            empty_r    <= (count_s == {(PTR_W + 1){1'b0}});
        end
    end

    // Storage array; contents need no reset because the flags guard reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign not_full = not_full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: buffered valid/ready commands in, one response per command out.
// Optional ACCESS-phase bus-hang timeout is enabled with `define APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);
    localparam int CMD_W = ADDR_WIDTH + 1 + DATA_WIDTH;

    apb_state_e            state_r, state_s;
    logic [CMD_W-1:0]      fifo_rdata_s;
    logic                  fifo_not_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  start_s;
    logic                  timeout_s;

    logic                  psel_r, psel_s;
    logic                  penable_r, penable_s;
    logic [ADDR_WIDTH-1:0] paddr_r, paddr_s;
    logic                  pwrite_r, pwrite_s;
    logic [DATA_WIDTH-1:0] pwdata_r, pwdata_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
    logic                  rsp_write_r, rsp_write_s;
    logic                  rsp_err_r, rsp_err_s;

    assign fifo_push_s = req_valid && fifo_not_full_s;
    // A transfer may start only if the response slot is free by the same edge.
    assign start_s     = !fifo_empty_s && (!rsp_valid_r || rsp_ready);
    assign fifo_pop_s  = (state_r == IDLE) && start_s;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (pclk),
        .rst_n     (preset_n),
        .push      (fifo_push_s),
        .push_data ({req_addr, req_write, req_wdata}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .not_full  (fifo_not_full_s),
        .empty     (fifo_empty_s)
    );

`ifdef APB_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W - 1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] tmo_cnt_r;

    // ACCESS wait-state counter, cleared while in SETUP.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == SETUP) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ACCESS) && !pready) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end

    assign timeout_s = (state_r == ACCESS) && !pready && (tmo_cnt_r == TMO_LAST);
`else
    logic unused_tmo_s;
    assign unused_tmo_s = ^TIMEOUT_CYCLES;
    assign timeout_s    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: state_s = ACCESS;
            ACCESS: begin
                if (pready || timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACCESS;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs.
    always_comb begin
        psel_s      = psel_r;
        penable_s   = penable_r;
        paddr_s     = paddr_r;
        pwrite_s    = pwrite_r;
        pwdata_s    = pwdata_r;
        if (rsp_valid_r && rsp_ready) begin
            rsp_valid_s = 1'b0;
            rsp_rdata_s = {DATA_WIDTH{1'b0}};
            rsp_write_s = 1'b0;
            rsp_err_s   = 1'b0;
        end else begin
            rsp_valid_s = rsp_valid_r;
            rsp_rdata_s = rsp_rdata_r;
            rsp_write_s = rsp_write_r;
            rsp_err_s   = rsp_err_r;
        end
        case (state_r)
            IDLE: begin
                penable_s = 1'b0;
                if (start_s) begin
                    psel_s   = 1'b1;
                    paddr_s  = fifo_rdata_s[CMD_W-1 -: ADDR_WIDTH];
                    pwrite_s = fifo_rdata_s[DATA_WIDTH];
                    pwdata_s = fifo_rdata_s[DATA_WIDTH-1:0];
                end else begin
                    psel_s = 1'b0;
                end
            end
            SETUP: begin
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ACCESS: begin
                if (pready || timeout_s) begin
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_write_s = pwrite_r;
                    rsp_err_s   = !pready;
                    rsp_rdata_s = (pready && !pwrite_r) ? prdata : {DATA_WIDTH{1'b0}};
                end else begin
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                end
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            paddr_r     <= {ADDR_WIDTH{1'b0}};
            pwrite_r    <= 1'b0;
            pwdata_r    <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            paddr_r     <= paddr_s;
            pwrite_r    <= pwrite_s;
            pwdata_r    <= pwdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_write_r <= rsp_write_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready = fifo_not_full_s;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign paddr     = paddr_r;
    assign pwrite    = pwrite_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_write = rsp_write_r;
    assign rsp_err   = rsp_err_r;

endmodule
